// File: rtl/adc_serial_pkg.sv
// adc_serial_pkg: shared FSM states, frame layout and header builder for the ADC serial responder.
package adc_serial_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int WRITE_BIT  = 15;
    localparam int ADD_HI     = 12;
    localparam int ADD_LO     = 10;
    localparam int SAMPLE_W   = 12;
    // DOUT frame: one zero bit, the channel address, then the sample, MSB first
    function automatic logic [FRAME_BITS-1:0] make_header(input logic [2:0] ch, input logic [SAMPLE_W-1:0] s);
        return {1'b0, ch, s};
    endfunction
endpackage

// File: rtl/adc_serial_responder_sync.sv
// adc_sync_edge: multi-flop synchronizer followed by one history flop producing rise/fall pulses.
module adc_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end
    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: emulates a serial ADC slave, returning {0, channel, sample} while collecting a 16-bit control word.
module adc_serial_responder
    import adc_serial_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_DIN,
    output logic              ADC_DOUT,
    input  logic [DATA_W-1:0] sample_in,
    output logic [2:0]        conv_ch,
    output logic [15:0]       ctrl_word,
    output logic              frame_done
);
    state_t                state, state_n;
    logic [FRAME_BITS-1:0] shift_out, shift_n, ctrl_sr, ctrl_sr_n, ctrl_n;
    logic [CNT_W-1:0]      bit_cnt, cnt_n;
    logic [2:0]            ch_n;
    logic                  done_n;
    logic                  cs_rise, cs_fall, sclk_rise, sclk_fall, din_s;
    logic [3:0]            unused_sync;

    adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .CLK(CLK), .reset(reset), .d(ADC_CS_N), .q(unused_sync[0]), .rise(cs_rise), .fall(cs_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .CLK(CLK), .reset(reset), .d(ADC_SCLK), .q(unused_sync[1]), .rise(sclk_rise), .fall(sclk_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
        .CLK(CLK), .reset(reset), .d(ADC_DIN), .q(din_s), .rise(unused_sync[2]), .fall(unused_sync[3]));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_out  <= '0;
            ctrl_sr    <= '0;
            bit_cnt    <= '0;
            ctrl_word  <= '0;
            conv_ch    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shift_out  <= shift_n;
            ctrl_sr    <= ctrl_sr_n;
            bit_cnt    <= cnt_n;
            ctrl_word  <= ctrl_n;
            conv_ch    <= ch_n;
            frame_done <= done_n;
        end
    end

    // CS edges are tested first so a coincident SCLK edge is dropped
    always_comb begin
        state_n   = state;
        shift_n   = shift_out;
        ctrl_sr_n = ctrl_sr;
        cnt_n     = bit_cnt;
        ctrl_n    = ctrl_word;
        ch_n      = conv_ch;
        done_n    = 1'b0;
        unique case (state)
            IDLE: if (cs_fall) begin
                state_n   = SHIFT;
                shift_n   = make_header(conv_ch, SAMPLE_W'(sample_in));
                cnt_n     = '0;
                ctrl_sr_n = '0;
            end
            SHIFT: if (cs_rise) begin
                state_n = IDLE;
            end else if (sclk_fall) begin
                shift_n = shift_out << 1;
            end else if (sclk_rise) begin
                ctrl_sr_n = {ctrl_sr[FRAME_BITS-2:0], din_s};
                cnt_n     = bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    state_n = DONE;
                    ctrl_n  = ctrl_sr_n;
                    ch_n    = ctrl_sr_n[WRITE_BIT] ? ctrl_sr_n[ADD_HI:ADD_LO] : conv_ch;
                    done_n  = 1'b1;
                end
            end
            DONE: if (cs_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign ADC_DOUT = (state == SHIFT) & shift_out[FRAME_BITS-1];
endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder: drives a serial ADC master against the responder and checks it with a frame-level model.
module tb_adc_serial_responder;
    localparam int SS = 2;
    localparam int H  = SS + 4;

    logic        CLK = 1'b0, reset = 1'b0;
    logic        ADC_CS_N = 1'b1, ADC_SCLK = 1'b1, ADC_DIN = 1'b0;
    logic [11:0] sample_in = '0;
    logic        ADC_DOUT, frame_done;
    logic [2:0]  conv_ch;
    logic [15:0] ctrl_word;

    adc_serial_responder #(.SYNC_STAGES(SS), .DATA_W(12)) dut (
        .CLK(CLK), .reset(reset), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN),
        .ADC_DOUT(ADC_DOUT), .sample_in(sample_in), .conv_ch(conv_ch), .ctrl_word(ctrl_word),
        .frame_done(frame_done));

    always #5 CLK = ~CLK;

    int          vectors = 0, miscompares = 0;
    int          m_frames = 0, fd_count = 0;
    logic [15:0] m_ctrl = '0;
    logic [2:0]  m_ch = '0;
    logic [11:0] cap = '0;
    logic        settled = 1'b0, toggle = 1'b0, prev_fd = 1'b0;
    logic [31:0] rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model of the master-visible bit stream: header bits then zeros past bit 16
    function automatic logic [31:0] exp_word(input logic [15:0] hdr, input int n);
        logic [31:0] e = '0;
        for (int i = 0; i < n; i++) e = {e[30:0], (i < 16) ? hdr[15-i] : 1'b0};
        return e;
    endfunction

    always @(negedge CLK) begin
        if (frame_done) begin
            fd_count++;
            chk("frame_done_width", {31'b0, prev_fd}, 32'd0);
        end
        prev_fd = frame_done;
        if (settled)
            chk("quiet_outputs", {11'b0, ADC_DOUT, ctrl_word, conv_ch, frame_done},
                {11'b0, 1'b0, m_ctrl, m_ch, 1'b0});
    end

    // one SCLK half period; optionally checks DOUT holds for SS clocks and moves on the next
    task automatic half(input bit cap_en, input bit lat, input logic old_b, input logic new_b);
        for (int j = 1; j <= H; j++) begin
            @(posedge CLK);
            if (cap_en && j == SS + 1) cap = sample_in;
            #1;
            if (lat && j == SS)     chk("dout_hold", {31'b0, ADC_DOUT}, {31'b0, old_b});
            if (lat && j == SS + 1) chk("dout_lag",  {31'b0, ADC_DOUT}, {31'b0, new_b});
            @(negedge CLK);
            if (toggle) sample_in = 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic frame(input int n, input logic [15:0] din, input logic [11:0] samp,
                         input bit tog, input bit rst_mid, output logic [31:0] word);
        logic [15:0] hdr;
        @(negedge CLK);
        settled   = 1'b0;
        toggle    = tog;
        sample_in = samp;
        ADC_CS_N  = 1'b0;
        half(1'b1, 1'b0, 1'b0, 1'b0);
        hdr  = {1'b0, m_ch, cap};
        word = '0;
        for (int k = 0; k < n; k++) begin
            word     = {word[30:0], ADC_DOUT};
            ADC_SCLK = 1'b0;
            ADC_DIN  = (k < 16) ? din[15-k] : 1'($urandom_range(0, 1));
            half(1'b0, 1'b1, (k < 16) ? hdr[15-k] : 1'b0, (k < 15) ? hdr[14-k] : 1'b0);
            ADC_SCLK = 1'b1;
            half(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("read_word", word, exp_word(hdr, n));
        toggle = 1'b0;
        if (rst_mid) begin
            reset = 1'b1;
            #1;
            chk("reset_outputs", {11'b0, ADC_DOUT, ctrl_word, conv_ch, frame_done}, 32'd0);
            m_ctrl   = '0;
            m_ch     = '0;
            ADC_CS_N = 1'b1;
            ADC_SCLK = 1'b1;
            repeat (2) @(negedge CLK);
            reset = 1'b0;
        end else begin
            ADC_CS_N = 1'b1;
            if (n >= 16) begin
                m_ctrl = din;
                if (din[15]) m_ch = din[12:10];
                m_frames++;
            end
        end
        repeat (H + 2) @(negedge CLK);
        chk("frame_done_count", fd_count, m_frames);
        settled = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_state", {11'b0, ADC_DOUT, ctrl_word, conv_ch, frame_done}, 32'd0);
        @(negedge CLK);
        reset   = 1'b0;
        settled = 1'b1;
        repeat (4) @(negedge CLK);

        frame(16, 16'h8C00, 12'hA5C, 1'b0, 1'b0, rd);
        chk("first_read", rd, 32'h0A5C);
        chk("first_ctrl", {16'b0, ctrl_word}, 32'h8C00);
        chk("first_ch", {29'b0, conv_ch}, 32'd3);
        chk("first_done", fd_count, 1);

        frame(16, 16'h0000, 12'h123, 1'b0, 1'b0, rd);
        chk("read_no_write", rd, 32'h3123);
        chk("ch_kept", {29'b0, conv_ch}, 32'd3);

        frame(7, 16'hA400, 12'h111, 1'b0, 1'b0, rd);
        chk("abort_ctrl", {16'b0, ctrl_word}, 32'h0000);
        chk("abort_ch", {29'b0, conv_ch}, 32'd3);
        chk("abort_done", fd_count, 2);

        frame(16, 16'h9400, 12'h456, 1'b0, 1'b0, rd);
        chk("after_abort_read", rd, 32'h3456);
        chk("after_abort_ch", {29'b0, conv_ch}, 32'd5);

        frame(20, 16'h8800, 12'h789, 1'b0, 1'b0, rd);
        chk("long_read", rd, 32'h57890);
        chk("long_ctrl", {16'b0, ctrl_word}, 32'h8800);
        chk("long_done", fd_count, 4);

        frame(9, 16'hFC00, 12'h2AA, 1'b0, 1'b1, rd);
        frame(16, 16'h0000, 12'hFFF, 1'b0, 1'b0, rd);
        chk("post_reset_read", rd, 32'h0FFF);

        frame(16, 16'hB000, 12'h3C3, 1'b1, 1'b0, rd);

        for (int f = 0; f < 12; f++)
            frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16,
                  16'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 1'b0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adc_serial_responder.md
ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth for ADC_SCLK/ADC_CS_N/ADC_DIN (legal 2..3).
REQ-002 Parameter: DATA_W, 12, sample width; frame length fixed at 16 bits.
REQ-003 CLK  input  1  system clock (50 MHz); the block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ADC_CS_N  input  1  frame select from serial ADC master, active low.
REQ-006 ADC_SCLK  input  1  serial clock from master, idle high.
REQ-007 ADC_DIN  input  1  control word from master, MSB first, sampled on SCLK rising.
REQ-008 ADC_DOUT  output  1  conversion result to master, MSB first, changes on SCLK falling.
REQ-009 sample_in  input  DATA_W  sample value for channel addressed by conv_ch.
REQ-010 conv_ch  output  3  channel address of the conversion in progress / next to capture.
REQ-011 ctrl_word  output  16  last complete control word received.
REQ-012 frame_done  output  1  one-CLK pulse after a complete 16-bit frame.

Function
REQ-013 ADC_CS_N, ADC_SCLK, ADC_DIN SHALL each pass through SYNC_STAGES flops, then one edge-detect flop; all decisions use synchronized signals.
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 IDLE -> SHIFT on synchronized CS_N falling edge; on that cycle capture shift_out = {1'b0, conv_ch, sample_in}, bit counter = 0.
REQ-016 In SHIFT, ADC_DOUT SHALL equal shift_out[15] from entry; each synchronized SCLK falling edge SHALL left-shift shift_out (fill 0).
REQ-017 In SHIFT, each synchronized SCLK rising edge SHALL shift ADC_DIN into a 16-bit ctrl shift register and increment the bit counter.
REQ-018 On the 16th rising edge: SHIFT -> DONE; ctrl_word loads assembled word; frame_done pulses on the next CLK.
REQ-019 If ctrl_word bit15 (WRITE) = 1 at frame completion, conv_ch SHALL load bits[12:10]; WRITE = 0 leaves conv_ch unchanged.
REQ-020 DONE: ADC_DOUT = 0; further SCLK edges ignored; DONE -> IDLE on CS_N rising.
REQ-021 CS_N rising while in SHIFT (aborted frame): -> IDLE; partial control word discarded; ctrl_word, conv_ch unchanged; no frame_done.
REQ-022 In IDLE, ADC_DOUT = 0 and SCLK edges are ignored.
REQ-023 Same-CLK CS_N falling and SCLK edge: CS_N edge takes priority; the SCLK edge is ignored.
REQ-024 Latency: ADC_DOUT update SHALL occur exactly SYNC_STAGES+1 CLK cycles after the raw SCLK falling edge; master SCLK half-period SHALL be >= SYNC_STAGES+2 CLK cycles.
REQ-025 sample_in SHALL be sampled only at frame start; changes mid-frame do not affect ADC_DOUT.

Reset
REQ-026 reset asserted: state IDLE, ADC_DOUT 0, conv_ch 0, ctrl_word 0, frame_done 0, counters and shift registers 0, synchronizers preset to idle (CS_N=1, SCLK=1, DIN=0).
REQ-027 reset mid-frame SHALL abandon the frame; after release a fresh CS_N falling edge is required to start a frame.

Structure
REQ-028 Shared package adc_serial_pkg: FSM state enum, FRAME_BITS=16, WRITE bit index 15, ADD field [12:10], DOUT header layout.
REQ-029 One sub-module: adc_sync_edge (parameterized synchronizer with rise/fall pulse outputs), instantiated per input.

Verification
REQ-030 reset, conv_ch=0, sample_in=12'hA5C, 16-bit frame DIN=16'h8C00 (WRITE=1, ADD=3) -> master reads 16'h0A5C; ctrl_word=16'h8C00; conv_ch=3; one frame_done pulse.
REQ-031 Next frame with sample_in=12'h123, DIN=16'h0000 -> reads 16'h3123; conv_ch stays 3.
REQ-032 CS_N raised after 7 SCLK cycles -> no frame_done; ctrl_word and conv_ch unchanged; following full frame reads correctly.
REQ-033 20 SCLK cycles within one CS_N low -> bits 17-20 read 0; exactly one frame_done; ctrl_word from first 16 bits.
REQ-034 reset asserted after 9 SCLK cycles -> all outputs 0 immediately; next full frame with sample_in=12'hFFF reads 16'h0FFF.
REQ-035 sample_in toggled every CLK during frame -> ADC_DOUT data equals value present on CS_N-falling capture cycle; DOUT edge lag = SYNC_STAGES+1 CLK.
